// File: rtl/immgen_pipe.sv
// Pipelined immediate generator: expands an IN_W-bit immediate field to OUT_W bits in one
// of four formats and hands it to execute through a valid/ready interface. A main register
// plus one skid register keep the stream loss-free while in_ready stays a pure flop output.
module immgen_pipe #(
  parameter int unsigned IN_W  = 22,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHAMT = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  immin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] immout
);

  // Number of bits added above the raw field.
  localparam int unsigned PAD = OUT_W - IN_W;

  logic [OUT_W-1:0]        zext;
  logic signed [OUT_W-1:0] left_just;
  logic [OUT_W-1:0]        sext;
  logic [OUT_W-1:0]        scaled;
  logic [OUT_W-1:0]        upper;
  logic [OUT_W-1:0]        fmt;

  logic [OUT_W-1:0] main_q, main_d;
  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q;

  logic accept;
  logic deliver;

  // Format expansion. Sign extension left-justifies the field and shifts it back
  // arithmetically, which also degenerates cleanly to identity when PAD is 0.
  always_comb begin
    zext      = OUT_W'(immin);
    left_just = $signed(zext << PAD);
    sext      = OUT_W'(left_just >>> PAD);
    scaled    = sext << SHAMT;
    upper     = zext << PAD;
    fmt       = sext;
    unique case (mode)
      2'b00: fmt = sext;
      2'b01: fmt = zext;
      2'b10: fmt = scaled;
      2'b11: fmt = upper;
    endcase
  end

  assign accept    = in_valid && ready_q;
  assign deliver   = main_valid_q && out_ready;
  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  assign immout    = main_q;

  // Next-state for the two-entry buffer; flush overrides every handshake.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Skid is never occupied while main is empty.
      if (accept) begin
        main_d       = fmt;
        main_valid_d = 1'b1;
      end
    end else if (deliver) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no accept can collide with the skid move.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = fmt;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = fmt;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; in_ready is registered as the complement of the next skid occupancy.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: directed format, backpressure, stream, flush and async-reset steps
// on the default configuration, then a random sweep over three parameter sets checked
// against a mask-based reference model through per-instance scoreboard queues.
module tb_immgen_pipe;

  logic        Clk;
  logic        Rst_n;
  logic [2:0]  flush_v;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [31:0] immin_v  [3];
  logic [1:0]  mode_v   [3];
  logic [31:0] immout_v [3];

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  int n_checks = 0;
  int n_fail   = 0;

  immgen_pipe #(.IN_W(22), .OUT_W(32), .SHAMT(2)) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .immin(immin_v[0][21:0]), .mode(mode_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .immout(immout_v[0])
  );

  immgen_pipe #(.IN_W(32), .OUT_W(32), .SHAMT(1)) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .immin(immin_v[1]), .mode(mode_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .immout(immout_v[1])
  );

  immgen_pipe #(.IN_W(12), .OUT_W(32), .SHAMT(1)) u_dut_c (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush_v[2]), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .immin(immin_v[2][11:0]), .mode(mode_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .immout(immout_v[2])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned inw_of(int id);
    return (id == 0) ? 22 : ((id == 1) ? 32 : 12);
  endfunction

  function automatic int unsigned sh_of(int id);
    return (id == 0) ? 2 : 1;
  endfunction

  // Reference expansion for OUT_W=32 built from masks rather than shifts.
  function automatic logic [31:0] ref_imm(int unsigned inw, int unsigned sh, logic [31:0] raw,
                                          logic [1:0] m);
    logic [31:0] mask;
    logic [31:0] z;
    logic [31:0] s;
    logic [31:0] r;
    mask = (inw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << inw) - 32'h1);
    z    = raw & mask;
    s    = (((z >> (inw - 1)) & 32'h1) != 0) ? (z | ~mask) : z;
    case (m)
      2'd0:    r = s;
      2'd1:    r = z;
      2'd2:    r = s << sh;
      default: r = z << (32 - inw);
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void sb_push(int id, logic [31:0] v);
    case (id)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int sb_size(int id);
    return (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q2.size());
  endfunction

  function automatic void sb_clear(int id);
    case (id)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic pop_check(int id);
    int          sz;
    logic [31:0] e;
    sz = sb_size(id);
    chk($sformatf("dut%0d_delivery_expected", id), 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("dut%0d_immout", id), immout_v[id], e);
    end
  endtask

  // Score deliveries happening on the coming edge, then move to the next falling edge.
  task automatic tick();
    for (int id = 0; id < 3; id++) begin
      if (out_valid_v[id] && out_ready_v[id]) pop_check(id);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Present one input for one edge, expecting it to be accepted.
  task automatic send(int id, logic [31:0] raw, logic [1:0] m, logic [31:0] exp);
    chk($sformatf("dut%0d_in_ready_at_send", id), 32'(in_ready_v[id]), 32'd1);
    in_valid_v[id] = 1'b1;
    immin_v[id]    = raw;
    mode_v[id]     = m;
    sb_push(id, exp);
    tick();
    in_valid_v[id] = 1'b0;
  endtask

  initial begin
    Rst_n       = 1'b0;
    flush_v     = '0;
    in_valid_v  = '0;
    out_ready_v = '0;
    for (int id = 0; id < 3; id++) begin
      immin_v[id] = '0;
      mode_v[id]  = '0;
    end

    #23;
    chk("reset_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("reset_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("reset_immout", immout_v[0], 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Formats, back to back with out_ready held high.
    out_ready_v[0] = 1'b1;
    send(0, 32'h200000, 2'b00, 32'hFFE00000);
    chk("fmt_latency_out_valid", 32'(out_valid_v[0]), 32'd1);
    send(0, 32'h3FFFFF, 2'b01, 32'h003FFFFF);
    chk("fmt_out_valid", 32'(out_valid_v[0]), 32'd1);
    send(0, 32'h3FFFFF, 2'b10, 32'hFFFFFFFC);
    chk("fmt_out_valid", 32'(out_valid_v[0]), 32'd1);
    send(0, 32'h000001, 2'b11, 32'h00000400);
    chk("fmt_out_valid", 32'(out_valid_v[0]), 32'd1);
    tick();
    chk("fmt_drained", 32'(out_valid_v[0]), 32'd0);

    // Backpressure: fill main and skid, then release.
    out_ready_v[0] = 1'b0;
    send(0, 32'h000005, 2'b00, 32'h00000005);
    send(0, 32'h000007, 2'b00, 32'h00000007);
    chk("bp_in_ready_low", 32'(in_ready_v[0]), 32'd0);
    chk("bp_out_valid", 32'(out_valid_v[0]), 32'd1);
    chk("bp_immout_held", immout_v[0], 32'h00000005);
    in_valid_v[0] = 1'b1;  // refused while full; must not enter the pipe
    immin_v[0]    = 32'h000009;
    tick();
    in_valid_v[0] = 1'b0;
    chk("bp_in_ready_still_low", 32'(in_ready_v[0]), 32'd0);
    chk("bp_immout_still_held", immout_v[0], 32'h00000005);
    out_ready_v[0] = 1'b1;
    tick();
    chk("bp_skid_moved_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("bp_second_value", immout_v[0], 32'h00000007);
    tick();
    chk("bp_empty_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("bp_empty_in_ready", 32'(in_ready_v[0]), 32'd1);

    // Continuous stream with simultaneous deliver and accept.
    for (int i = 0; i < 8; i++) begin
      send(0, 32'(i * 3 + 1), 2'b01, 32'(i * 3 + 1));
    end
    tick();
    chk("stream_drained", 32'(out_valid_v[0]), 32'd0);
    chk("stream_all_delivered", 32'(sb_size(0)), 32'd0);

    // Flush with two entries held and a concurrent input.
    out_ready_v[0] = 1'b0;
    send(0, 32'h000011, 2'b00, 32'h00000011);
    send(0, 32'h000022, 2'b00, 32'h00000022);
    in_valid_v[0] = 1'b1;
    immin_v[0]    = 32'h000033;
    flush_v[0]    = 1'b1;
    tick();
    flush_v[0]    = 1'b0;
    in_valid_v[0] = 1'b0;
    sb_clear(0);
    chk("flush_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("flush_in_ready", 32'(in_ready_v[0]), 32'd1);
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_stale", 32'(out_valid_v[0]), 32'd0);
    end

    // Asynchronous reset asserted between edges during a stall.
    out_ready_v[0] = 1'b0;
    send(0, 32'h000044, 2'b01, 32'h00000044);
    send(0, 32'h000055, 2'b01, 32'h00000055);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("areset_immout", immout_v[0], 32'h0);
    chk("areset_in_ready", 32'(in_ready_v[0]), 32'd1);
    sb_clear(0);
    #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    out_ready_v[0] = 1'b1;
    send(0, 32'h00000A, 2'b01, 32'h0000000A);
    tick();
    chk("areset_recover_drained", 32'(out_valid_v[0]), 32'd0);

    // Other parameter sets: identity at full width, scaled narrow field.
    out_ready_v = 3'b111;
    send(2, 32'hFFF, 2'b10, 32'hFFFFFFFE);
    send(1, 32'h80000001, 2'b00, 32'h80000001);
    send(1, 32'h80000001, 2'b11, 32'h80000001);
    send(1, 32'h80000001, 2'b10, 32'h00000002);
    tick();

    // Random sweep on all three instances with random backpressure.
    for (int n = 0; n < 1000; n++) begin
      for (int id = 0; id < 3; id++) begin
        out_ready_v[id] = 1'($urandom_range(0, 1));
        in_valid_v[id]  = 1'($urandom_range(0, 1));
        immin_v[id]     = $urandom;
        mode_v[id]      = 2'($urandom_range(0, 3));
        if (in_valid_v[id] && in_ready_v[id]) begin
          sb_push(id, ref_imm(inw_of(id), sh_of(id), immin_v[id], mode_v[id]));
        end
      end
      tick();
    end
    in_valid_v  = '0;
    out_ready_v = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("dut%0d_sweep_queue_empty", id), 32'(sb_size(id)), 32'd0);
      chk($sformatf("dut%0d_sweep_out_valid", id), 32'(out_valid_v[id]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
